servo_toggle_ctrl: RTL
======================

Name: servo_toggle_ctrl

Overview:
- Upstream command stage for the three-channel servo top level. Produces the per-channel `toggle` levels that each servo driver consumes; each servo driver mirrors its toggle onto its own LED.
- Takes raw DE2-115 push-button levels and applies, per channel, a 2-flop synchronizer, a counter-based debouncer, press-edge detection, a toggle latch, and a post-toggle lockout window.
- The lockout window gives the servo time to finish its move before another command is accepted.
- Channels are fully independent.

Parameters:
- NCH, 3: number of channels (one per servo).
- DEBOUNCE_CYCLES, 1000000: cycles a new synchronized level must hold before it is accepted (20 ms at 50 MHz). Minimum 2.
- LOCKOUT_CYCLES, 25000000: cycles after a toggle during which further presses are ignored (0.5 s at 50 MHz). Minimum 1.
- BTN_ACTIVE_LOW, 1: 1 means a raw 0 is "pressed" (DE2-115 KEY inputs); 0 means a raw 1 is "pressed".

Ports:
- mclk, input, 1: system clock (50 MHz); all logic is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- btn_raw, input, NCH: raw asynchronous button levels.
- toggle, output, NCH: toggle command level per channel; bit i drives the toggle input of servo i.
- busy, output, NCH: 1 while channel i is in lockout.
- press_pulse, output, NCH: one-cycle strobe on each debounced press, including presses ignored during lockout.
- ignored, output, NCH: one-cycle strobe when a debounced press arrives while the channel is busy.

Behaviour:
- Reset (async assert, sync release by the system):
  - toggle=0, busy=0, press_pulse=0, ignored=0.
  - Synchronizer flops and debounced stable state = released level. All counters = 0. FSM = IDLE.
- Synchronizer:
  - Two flops per channel.
  - The normalized level is pressed=1 after BTN_ACTIVE_LOW inversion.
- Debouncer (per channel):
  - Counter width = $clog2(DEBOUNCE_CYCLES).
  - If sync2 == stable: counter clears.
  - Else the counter increments each cycle. On the cycle it equals DEBOUNCE_CYCLES-1 while still mismatched, stable <= sync2 and the counter clears.
  - Any mismatch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Edge detect:
  - press_pulse[i] is registered and asserts for exactly one cycle after stable goes 0->1.
  - A release (1->0) produces no pulse.
- Per-channel FSM, states IDLE and LOCK:
  - IDLE with press_pulse=1: toggle inverts, busy<=1, lock counter<=0, go to LOCK.
  - LOCK: lock counter increments each cycle. At LOCKOUT_CYCLES-1, busy<=0 and go to IDLE (the lockout lasts exactly LOCKOUT_CYCLES cycles).
  - LOCK with press_pulse=1: toggle unchanged, ignored pulses for 1 cycle, lock counter not restarted.
- Latency:
  - From the first cycle btn_raw holds a steady pressed level to the toggle change = 2 (sync) + DEBOUNCE_CYCLES (filter) + 1 (pulse register) + 1 (toggle register) edges.
  - busy rises on the same edge as toggle.
- Boundaries:
  - Button held through lockout expiry: no retrigger (edge-based); a release and a fresh press are required.
  - Press pulse on the same cycle LOCK expires: the FSM is still in LOCK, so the press is ignored.
  - Channels pressed simultaneously toggle on the same edge, independently.
  - rst_n asserted mid-lockout or mid-debounce clears everything immediately. After release, a button still held reads as "released" in stable, so it triggers once after DEBOUNCE_CYCLES.
  - Counters never wrap: the debounce counter saturates by clearing; the lock counter stops at the terminal count.

Test Plan (NCH=3, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, BTN_ACTIVE_LOW=1):
1. Reset, then btn_raw[0] held 0 for 20 cycles -> press_pulse[0] is 1 for 1 cycle; toggle[0] goes 0->1 exactly 8 edges after the first sampled 0; busy[0] is high for 10 cycles; channels 1 and 2 stay at 0.
2. btn_raw[1] low for 3 cycles, then high -> no press_pulse, toggle[1]=0. A 4-cycle low -> press_pulse[1] fires once.
3. Channel 0: press, release, then press again 5 cycles after the toggle (inside lockout) -> ignored[0]=1 for 1 cycle, toggle[0] stays 1, busy[0] drops at cycle 10. A third press after that -> toggle[0]=0.
4. Hold btn_raw[2]=0 for 40 cycles -> exactly one toggle and one press_pulse; no retrigger after busy falls.
5. All three buttons pressed on the same cycle -> toggle goes 000->111 on a single edge; busy=111 for 10 cycles.
6. rst_n pulsed low 3 cycles after a toggle while busy=1 and the button is held -> toggle=0, busy=0 immediately. After reset release the held button re-debounces and toggle=1 eight edges later.

Source files
------------

// File: rtl/servo_toggle_ctrl.sv
// Per-channel button front end for the servo top level: sync, debounce, press
// edge, toggle latch and a post-toggle lockout so a servo can finish its move.
module servo_toggle_ctrl #(
  parameter int NCH             = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCKOUT_CYCLES  = 25000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic [NCH-1:0] btn_raw,
  output logic [NCH-1:0] toggle,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] press_pulse,
  output logic [NCH-1:0] ignored
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Everything downstream of this point works on "pressed = 1".
  logic [NCH-1:0] w_btn_norm;
  assign w_btn_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] r_stable;
  logic [NCH-1:0] r_stable_d;
  logic [DW-1:0]  r_deb_cnt [NCH];
  logic [NCH-1:0] r_press_pulse;
  logic [NCH-1:0] r_toggle;
  logic [NCH-1:0] r_busy;
  logic [NCH-1:0] r_ignored;
  state_t         r_state [NCH];
  logic [LW-1:0]  r_lock_cnt [NCH];

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_norm;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d    <= '0;
      r_press_pulse <= '0;
    end else begin
      r_stable_d    <= r_stable;
      r_press_pulse <= r_stable & ~r_stable_d;
    end
  end

  // Lock counter holds at its terminal value until the next accepted press.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle  <= '0;
      r_busy    <= '0;
      r_ignored <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_state[i]    <= ST_IDLE;
        r_lock_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_ignored[i] <= 1'b0;
        case (r_state[i])
          ST_IDLE: begin
            if (r_press_pulse[i]) begin
              r_toggle[i]   <= ~r_toggle[i];
              r_busy[i]     <= 1'b1;
              r_lock_cnt[i] <= '0;
              r_state[i]    <= ST_LOCK;
            end
          end
          ST_LOCK: begin
            if (r_press_pulse[i]) begin
              r_ignored[i] <= 1'b1;
            end
            if (r_lock_cnt[i] == LOCK_LAST) begin
              r_busy[i]  <= 1'b0;
              r_state[i] <= ST_IDLE;
            end else begin
              r_lock_cnt[i] <= r_lock_cnt[i] + 1'b1;
            end
          end
          default: begin
            r_busy[i]  <= 1'b0;
            r_state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign toggle      = r_toggle;
  assign busy        = r_busy;
  assign press_pulse = r_press_pulse;
  assign ignored     = r_ignored;

endmodule
